// File: rtl/mem_channel_interleaver.sv
// Block-interleaves bus memory requests across channels and returns read data in issue order.
// Optional MEMSYS_INTLV_HASH_EN folds the next address bits into the channel select.
module mem_channel_interleaver #(
  parameter int num_channels_p    = 2,
  parameter int block_width_p     = 16,
  parameter int dma_data_width_p  = 4,
  parameter int max_outstanding_p = 8,
  parameter int resp_depth_p      = 4,
  localparam int dw_lp            = dma_data_width_p * 32
) (
  input  logic                                    clk_i,
  input  logic                                    nreset_i,
  input  logic                                    bm_valid_i,
  output logic                                    bm_ready_o,
  input  logic                                    bm_we_i,
  input  logic [31:0]                             bm_addr_i,
  input  logic [dw_lp-1:0]                        bm_wdata_i,
  output logic                                    bm_valid_o,
  output logic [dw_lp-1:0]                        bm_data_o,
  output logic [num_channels_p-1:0]               ch_valid_o,
  input  logic [num_channels_p-1:0]               ch_ready_i,
  output logic [num_channels_p-1:0]               ch_we_o,
  output logic [num_channels_p-1:0][31:0]         ch_addr_o,
  output logic [num_channels_p-1:0][dw_lp-1:0]    ch_wdata_o,
  input  logic [num_channels_p-1:0]               ch_valid_i,
  input  logic [num_channels_p-1:0][dw_lp-1:0]    ch_data_i
);

  localparam int offset_width_lp = $clog2(block_width_p) + 2;
  localparam int cw_lp           = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
  localparam int credit_w_lp     = $clog2(resp_depth_p + 1);
  localparam int oaw_lp          = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int raw_lp          = (resp_depth_p > 1) ? $clog2(resp_depth_p) : 1;

  logic [cw_lp-1:0]                          sel;
  logic                                      ok;
  logic                                      rd_fire;
  logic                                      pop_any;
  logic [cw_lp-1:0]                          ord_head;
  logic                                      ord_full;
  logic                                      ord_empty;
  logic [credit_w_lp-1:0]                    credit [num_channels_p];
  logic [num_channels_p-1:0]                 resp_empty;
  logic [num_channels_p-1:0][dw_lp-1:0]      resp_data;

  generate
    if (num_channels_p == 1) begin : g_sel_single
      assign sel = '0;
    end else begin : g_sel_multi
`ifdef MEMSYS_INTLV_HASH_EN
      assign sel = bm_addr_i[offset_width_lp +: cw_lp] ^ bm_addr_i[offset_width_lp + cw_lp +: cw_lp];
`else
      assign sel = bm_addr_i[offset_width_lp +: cw_lp];
`endif
    end
  endgenerate

  // Writes never produce a response, so only reads consume credit and order slots.
  assign ok         = bm_we_i | ((credit[sel] != '0) & ~ord_full);
  assign bm_ready_o = nreset_i & ok & ch_ready_i[sel];
  assign rd_fire    = bm_valid_i & bm_ready_o & ~bm_we_i;

  // Order FIFO: channel index of every read in issue order.
  logic [cw_lp-1:0]  ord_mem [max_outstanding_p];
  logic [oaw_lp-1:0] ord_wr_idx_q, ord_wr_idx_d, ord_rd_idx_q, ord_rd_idx_d;
  logic              ord_wr_wrap_q, ord_wr_wrap_d, ord_rd_wrap_q, ord_rd_wrap_d;

  assign ord_full  = (ord_wr_idx_q == ord_rd_idx_q) & (ord_wr_wrap_q != ord_rd_wrap_q);
  assign ord_empty = (ord_wr_idx_q == ord_rd_idx_q) & (ord_wr_wrap_q == ord_rd_wrap_q);
  assign ord_head  = ord_mem[ord_rd_idx_q];
  assign pop_any   = ~ord_empty & ~resp_empty[ord_head];

  always_comb begin
    ord_wr_idx_d  = ord_wr_idx_q;
    ord_wr_wrap_d = ord_wr_wrap_q;
    ord_rd_idx_d  = ord_rd_idx_q;
    ord_rd_wrap_d = ord_rd_wrap_q;
    if (rd_fire) begin
      if (ord_wr_idx_q == oaw_lp'(max_outstanding_p - 1)) begin
        ord_wr_idx_d  = '0;
        ord_wr_wrap_d = ~ord_wr_wrap_q;
      end else begin
        ord_wr_idx_d = ord_wr_idx_q + 1'b1;
      end
    end
    if (pop_any) begin
      if (ord_rd_idx_q == oaw_lp'(max_outstanding_p - 1)) begin
        ord_rd_idx_d  = '0;
        ord_rd_wrap_d = ~ord_rd_wrap_q;
      end else begin
        ord_rd_idx_d = ord_rd_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_fire) ord_mem[ord_wr_idx_q] <= sel;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      ord_wr_idx_q  <= '0;
      ord_wr_wrap_q <= 1'b0;
      ord_rd_idx_q  <= '0;
      ord_rd_wrap_q <= 1'b0;
    end else begin
      ord_wr_idx_q  <= ord_wr_idx_d;
      ord_wr_wrap_q <= ord_wr_wrap_d;
      ord_rd_idx_q  <= ord_rd_idx_d;
      ord_rd_wrap_q <= ord_rd_wrap_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < num_channels_p; gi++) begin : g_ch
      logic [dw_lp-1:0]       mem [resp_depth_p];
      logic [raw_lp-1:0]      wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
      logic                   wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
      logic [credit_w_lp-1:0] credit_q, credit_d;
      logic                   full, push, pop, take;

      assign full            = (wr_idx_q == rd_idx_q) & (wr_wrap_q != rd_wrap_q);
      assign resp_empty[gi]  = (wr_idx_q == rd_idx_q) & (wr_wrap_q == rd_wrap_q);
      assign resp_data[gi]   = mem[rd_idx_q];
      assign push            = ch_valid_i[gi] & ~full;
      assign pop             = pop_any & (ord_head == cw_lp'(gi));
      assign take            = rd_fire & (sel == cw_lp'(gi));
      assign credit[gi]      = credit_q;
      assign ch_valid_o[gi]  = nreset_i & bm_valid_i & ok & (sel == cw_lp'(gi));
      assign ch_we_o[gi]     = bm_we_i;
      assign ch_addr_o[gi]   = bm_addr_i;
      assign ch_wdata_o[gi]  = bm_wdata_i;

      always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_wrap_d = wr_wrap_q;
        rd_idx_d  = rd_idx_q;
        rd_wrap_d = rd_wrap_q;
        credit_d  = credit_q;
        if (push) begin
          if (wr_idx_q == raw_lp'(resp_depth_p - 1)) begin
            wr_idx_d  = '0;
            wr_wrap_d = ~wr_wrap_q;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
        if (pop) begin
          if (rd_idx_q == raw_lp'(resp_depth_p - 1)) begin
            rd_idx_d  = '0;
            rd_wrap_d = ~rd_wrap_q;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
        if (take & ~pop) credit_d = credit_q - 1'b1;
        else if (pop & ~take) credit_d = credit_q + 1'b1;
      end

      // A beat arriving while full is dropped; the channel has no backpressure.
      always_ff @(posedge clk_i) begin
        if (push) mem[wr_idx_q] <= ch_data_i[gi];
      end

      always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
          wr_idx_q  <= '0;
          wr_wrap_q <= 1'b0;
          rd_idx_q  <= '0;
          rd_wrap_q <= 1'b0;
          credit_q  <= credit_w_lp'(resp_depth_p);
        end else begin
          wr_idx_q  <= wr_idx_d;
          wr_wrap_q <= wr_wrap_d;
          rd_idx_q  <= rd_idx_d;
          rd_wrap_q <= rd_wrap_d;
          credit_q  <= credit_d;
        end
      end
    end
  endgenerate

  logic             bm_valid_q;
  logic [dw_lp-1:0] bm_data_q;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      bm_valid_q <= 1'b0;
      bm_data_q  <= '0;
    end else begin
      bm_valid_q <= pop_any;
      if (pop_any) bm_data_q <= resp_data[ord_head];
    end
  end

  assign bm_valid_o = bm_valid_q;
  assign bm_data_o  = bm_data_q;

endmodule

// File: tb/tb_mem_channel_interleaver.sv
// Directed bench for mem_channel_interleaver: stimulus pushes expected read data into a
// queue, an independent monitor pops and compares on every bm_valid_o beat.
module tb_mem_channel_interleaver;

`ifdef MEMSYS_INTLV_HASH_EN
  localparam int hash_ch = 1;
`else
  localparam int hash_ch = 0;
`endif

  logic              clk;
  logic              nreset_i;
  logic              bm_valid_i;
  logic              bm_ready_o;
  logic              bm_we_i;
  logic [31:0]       bm_addr_i;
  logic [127:0]      bm_wdata_i;
  logic              bm_valid_o;
  logic [127:0]      bm_data_o;
  logic [1:0]        ch_valid_o;
  logic [1:0]        ch_ready_i;
  logic [1:0]        ch_we_o;
  logic [1:0][31:0]  ch_addr_o;
  logic [1:0][127:0] ch_wdata_o;
  logic [1:0]        ch_valid_i;
  logic [1:0][127:0] ch_data_i;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q [$];
  logic [127:0] mon_exp;

  mem_channel_interleaver #(
    .num_channels_p(2), .block_width_p(16), .dma_data_width_p(4),
    .max_outstanding_p(8), .resp_depth_p(4)
  ) dut (
    .clk_i(clk), .nreset_i(nreset_i),
    .bm_valid_i(bm_valid_i), .bm_ready_o(bm_ready_o), .bm_we_i(bm_we_i),
    .bm_addr_i(bm_addr_i), .bm_wdata_i(bm_wdata_i),
    .bm_valid_o(bm_valid_o), .bm_data_o(bm_data_o),
    .ch_valid_o(ch_valid_o), .ch_ready_i(ch_ready_i), .ch_we_o(ch_we_o),
    .ch_addr_o(ch_addr_o), .ch_wdata_o(ch_wdata_o),
    .ch_valid_i(ch_valid_i), .ch_data_i(ch_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every response beat must match the oldest expected value.
  always @(negedge clk) begin
    if (nreset_i && bm_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got 0x%0h required no response", bm_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("RESP data=0x%0h", bm_data_o);
        chk("resp_data", bm_data_o, mon_exp);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [127:0] wd);
    int n;
    n = 0;
    @(posedge clk); #1;
    bm_valid_i = 1'b1; bm_we_i = we; bm_addr_i = addr; bm_wdata_i = wd;
    #1;
    while (!bm_ready_o && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("issue_accept", {127'b0, bm_ready_o}, 128'd1);
    $display("REQ we=%0d addr=0x%0h", we, addr);
    @(posedge clk); #1;
    bm_valid_i = 1'b0; bm_we_i = 1'b0;
  endtask

  task automatic resp(input int ch, input logic [127:0] d);
    @(posedge clk); #1;
    ch_valid_i = '0; ch_valid_i[ch] = 1'b1; ch_data_i[ch] = d;
    @(posedge clk); #1;
    ch_valid_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset_i = 1'b0; bm_valid_i = 1'b1; bm_we_i = 1'b0; bm_addr_i = '0; bm_wdata_i = '0;
    ch_ready_i = 2'b11; ch_valid_i = '0; ch_data_i = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_bm_valid", {127'b0, bm_valid_o}, 128'd0);
    chk("reset_ch_valid", {126'b0, ch_valid_o}, 128'd0);
    chk("reset_bm_data", bm_data_o, 128'd0);
    chk("reset_ready", {127'b0, bm_ready_o}, 128'd0);
    bm_valid_i = 1'b0;
    @(negedge clk);
    nreset_i = 1'b1;

    // Write to channel 1: broadcast fields, single valid, never a response.
    @(posedge clk); #1;
    bm_valid_i = 1'b1; bm_we_i = 1'b1; bm_addr_i = 32'h40; bm_wdata_i = 128'h55;
    #1;
    chk("write_ch_valid", {126'b0, ch_valid_o}, 128'd2);
    chk("write_ready", {127'b0, bm_ready_o}, 128'd1);
    chk("write_ch_we", {126'b0, ch_we_o}, 128'd3);
    chk("write_ch_addr", {96'b0, ch_addr_o[1]}, 128'h40);
    chk("write_ch_wdata", ch_wdata_o[0], 128'h55);
    @(posedge clk); #1;
    bm_valid_i = 1'b0; bm_we_i = 1'b0;
    repeat (4) @(posedge clk);

    // Hashed/plain select of 0x080, then two-cycle return latency.
    @(posedge clk); #1;
    bm_valid_i = 1'b1; bm_we_i = 1'b0; bm_addr_i = 32'h80;
    #1;
    chk("hash_ch_valid", {126'b0, ch_valid_o}, 128'(1 << hash_ch));
    chk("hash_ready", {127'b0, bm_ready_o}, 128'd1);
    @(posedge clk); #1;
    bm_valid_i = 1'b0;
    exp_q.push_back(128'h80);
    @(posedge clk); #1;
    ch_valid_i[hash_ch] = 1'b1; ch_data_i[hash_ch] = 128'h80;
    @(posedge clk); #1;
    ch_valid_i = '0;
    #1;
    chk("latency_cycle1", {127'b0, bm_valid_o}, 128'd0);
    @(posedge clk); #2;
    chk("latency_cycle2", {127'b0, bm_valid_o}, 128'd1);
    repeat (3) @(posedge clk);

    // Reorder: channel 1 answers first, output still follows issue order.
    issue(1'b0, 32'h000, '0); exp_q.push_back(128'hA);
    issue(1'b0, 32'h040, '0); exp_q.push_back(128'hB);
    resp(1, 128'hB);
    repeat (3) @(posedge clk);
    #2;
    chk("reorder_hold", {127'b0, bm_valid_o}, 128'd0);
    resp(0, 128'hA);
    repeat (5) @(posedge clk);
    chk("reorder_drain", 128'(exp_q.size()), 128'd0);

    // Credit stall on channel 0.
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'(i * 16), '0);
      exp_q.push_back(128'(32'h100 + i));
    end
    @(posedge clk); #1;
    bm_valid_i = 1'b1; bm_we_i = 1'b0; bm_addr_i = 32'h000;
    #1;
    chk("credit_stall", {127'b0, bm_ready_o}, 128'd0);
    ch_valid_i = 2'b01; ch_data_i[0] = 128'h100;
    @(posedge clk); #1;
    ch_valid_i = '0;
    #1;
    chk("credit_stall_hold", {127'b0, bm_ready_o}, 128'd0);
    @(posedge clk); #2;
    chk("credit_release", {127'b0, bm_ready_o}, 128'd1);
    @(posedge clk); #1;
    bm_valid_i = 1'b0;
    exp_q.push_back(128'h104);
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      ch_valid_i = 2'b01; ch_data_i[0] = 128'(32'h100 + i);
    end
    @(posedge clk); #1;
    ch_valid_i = '0;
    #1;
    chk("throughput_0", {127'b0, bm_valid_o}, 128'd1);
    @(posedge clk); #2;
    chk("throughput_1", {127'b0, bm_valid_o}, 128'd1);
    @(posedge clk); #2;
    chk("throughput_end", {127'b0, bm_valid_o}, 128'd0);
    repeat (3) @(posedge clk);

    // Order FIFO full: reads stall, writes still pass.
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, (i % 2 == 1) ? 32'h040 : 32'h000, '0);
      exp_q.push_back(128'(32'h200 + i));
    end
    @(posedge clk); #1;
    bm_valid_i = 1'b1; bm_we_i = 1'b0; bm_addr_i = 32'h000;
    #1;
    chk("order_full_stall", {127'b0, bm_ready_o}, 128'd0);
    chk("order_full_ch_valid", {126'b0, ch_valid_o}, 128'd0);
    bm_we_i = 1'b1; bm_addr_i = 32'h040; bm_wdata_i = 128'h77;
    #1;
    chk("order_full_write", {127'b0, bm_ready_o}, 128'd1);
    chk("order_full_write_ch", {126'b0, ch_valid_o}, 128'd2);
    @(posedge clk); #1;
    bm_valid_i = 1'b0; bm_we_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      ch_valid_i = 2'b11;
      ch_data_i[0] = 128'(32'h200 + 2 * j);
      ch_data_i[1] = 128'(32'h201 + 2 * j);
    end
    @(posedge clk); #1;
    ch_valid_i = '0;
    repeat (15) @(posedge clk);
    chk("final_drain", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
